hilo_div_ctrl: RTL and testbench

//  Multi-cycle sequencer for the DIV instruction and its HI/LO result. Takes a DIV issued from the

---
 rtl/cpu_ctrl_pkg.sv | 18 +
 rtl/hilo_div_ctrl_if.sv | 27 ++
 rtl/hilo_div_ctrl_div_step.sv | 20 ++
 rtl/hilo_div_ctrl.sv | 129 ++++++++++++
 tb/tb_hilo_div_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared CPU control definitions: divider sequencer states and the decode
// field encodings that identify a DIV issue.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        ITER,
        FIX
    } div_state_e;

    localparam logic [2:0] ALUCTR_DIV  = 3'd4;
    localparam logic [2:0] MEMCTR_HILO = 3'd6;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

endpackage

// File: rtl/hilo_div_ctrl_if.sv
// Issue/result bundle between the execute stage and the HI/LO divide sequencer.
interface hilo_div_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             mf_req;
    logic             flush;
    logic             busy;
    logic             stall;
    logic             hilo_we;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;

    modport master (
        output start, is_signed, dividend, divisor, mf_req, flush,
        input  busy, stall, hilo_we, hi, lo, div_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor, mf_req, flush,
        output busy, stall, hilo_we, hi, lo, div_zero
    );
endinterface

// File: rtl/hilo_div_ctrl_div_step.sv
// One radix-2 restoring division step on unsigned magnitudes: shift the next
// dividend bit into the remainder, trial-subtract, and record the quotient bit.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvsr,
    output logic [WIDTH-1:0] rem_nx,
    output logic [WIDTH-1:0] quo_nx
);
    logic [WIDTH:0] shifted;
    logic           fits;

    // The shifted remainder can reach 2*dvsr-1, so it needs one extra bit.
    assign shifted = {rem, quo[WIDTH-1]};
    assign fits    = (shifted >= {1'b0, dvsr});
    assign rem_nx  = fits ? WIDTH'(shifted - {1'b0, dvsr}) : shifted[WIDTH-1:0];
    assign quo_nx  = {quo[WIDTH-2:0], fits};
endmodule

// File: rtl/hilo_div_ctrl.sv
// DIV/DIVU sequencer: one quotient bit per cycle, single HI/LO write pulse at
// completion, and front-end stall while HI/LO are pending.
module hilo_div_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    hilo_div_ctrl_if.slave bus
);
    div_state_e           state, state_nx;
    logic [DIV_CNT_W-1:0] count, count_nx;

    logic             sgn_en;
    logic [WIDTH-1:0] dvd_raw;
    logic [WIDTH-1:0] dvs_raw;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    logic [WIDTH-1:0] hi, lo, hi_nx, lo_nx;
    logic             div_zero;
    logic             dvs_zero, q_neg, r_neg;
    logic             accept, busy, hilo_we;

    // Extend by one bit before negating so the most negative value has a magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic en);
        logic signed [WIDTH:0] wide;
        wide = $signed({en & v[WIDTH-1], v});
        if (wide < 0) wide = -wide;
        return wide[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem    (rem),
        .quo    (quo),
        .dvsr   (dvs_mag),
        .rem_nx (rem_step),
        .quo_nx (quo_step)
    );

    assign dvs_zero = (dvs_raw == '0);
    assign q_neg    = sgn_en & (dvd_raw[WIDTH-1] ^ dvs_raw[WIDTH-1]);
    assign r_neg    = sgn_en & dvd_raw[WIDTH-1];
    assign lo_nx    = dvs_zero ? '1 : apply_sign(quo, q_neg);
    assign hi_nx    = dvs_zero ? dvd_raw : apply_sign(rem, r_neg);

    assign accept  = (state == IDLE) && bus.start && !bus.flush;
    assign busy    = (state != IDLE);
    assign hilo_we = (state == FIX) && !bus.flush;

    always_comb begin
        state_nx = state;
        count_nx = count;
        unique case (state)
            IDLE: if (accept) state_nx = PREP;
            PREP: begin
                if (bus.flush) begin
                    state_nx = IDLE;
                end else if (dvs_zero) begin
                    state_nx = FIX;
                end else begin
                    state_nx = ITER;
                    count_nx = '0;
                end
            end
            ITER: begin
                if (bus.flush) begin
                    state_nx = IDLE;
                end else begin
                    count_nx = count + 1'b1;
                    if (count == DIV_CNT_W'(WIDTH - 1)) state_nx = FIX;
                end
            end
            FIX: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ---- control and architectural HI/LO state ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            count    <= '0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            if (hilo_we) begin
                hi       <= hi_nx;
                lo       <= lo_nx;
                div_zero <= dvs_zero;
            end
        end
    end

    // ---- operand capture and iteration datapath ----
    always_ff @(posedge clk) begin
        if (accept) begin
            sgn_en  <= bus.is_signed;
            dvd_raw <= bus.dividend;
            dvs_raw <= bus.divisor;
        end
        if (state == PREP) begin
            rem     <= '0;
            quo     <= magnitude(dvd_raw, sgn_en);
            dvs_mag <= magnitude(dvs_raw, sgn_en);
        end else if (state == ITER) begin
            rem <= rem_step;
            quo <= quo_step;
        end
    end

    assign bus.busy     = busy;
    assign bus.stall    = busy & (bus.start | bus.mf_req);
    assign bus.hilo_we  = hilo_we;
    assign bus.hi       = hi;
    assign bus.lo       = lo;
    assign bus.div_zero = div_zero;
endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Scoreboard bench for hilo_div_ctrl: directed corner cases plus random divides
// checked against an arithmetic reference model.
module tb_hilo_div_ctrl;
    import cpu_ctrl_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           wcyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] memctr = 3'd0;
    logic [2:0] aluctr = 3'd0;
    int         cyc = 0;
    int         chk_cnt = 0;
    int         pass_cnt = 0;
    exp_t       exp_q[$];
    logic [W-1:0] last_hi = '0;
    logic [W-1:0] last_lo = '0;
    logic         last_dz = 1'b0;

    hilo_div_ctrl_if #(.WIDTH(W)) bus();

    hilo_div_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.start = (memctr == MEMCTR_HILO) && (aluctr == ALUCTR_DIV);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sgn, input int c0);
        exp_t e;
        int   sa, sb;
        sa     = a;
        sb     = b;
        e.dz   = 1'b0;
        e.wcyc = c0 + ((b == 0) ? 2 : LAT);
        if (b == 0) begin
            e.dz = 1'b1;
            e.lo = '1;
            e.hi = a;
        end else if (!sgn) begin
            e.lo = a / b;
            e.hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.lo = a;
            e.hi = '0;
        end else begin
            e.lo = sa / sb;
            e.hi = sa % sb;
        end
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return W'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        exp_t e;
        e = model(a, b, sgn, cyc);
        exp_q.push_back(e);
        last_hi = e.hi;
        last_lo = e.lo;
        last_dz = e.dz;
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sgn, input bit expect_w);
        memctr        = MEMCTR_HILO;
        aluctr        = ALUCTR_DIV;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.is_signed = sgn;
        if (expect_w) push(a, b, sgn);
        step();
        aluctr = 3'd0;
    endtask

    // Entered in the cycle after issue; busy must cover exactly lat cycles.
    task automatic finish_div(input int lat);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            check_bit("busy", bus.busy, k <= lat);
            step();
        end
    endtask

    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        issue(a, b, sgn, 1'b1);
        finish_div((b == 0) ? 2 : LAT);
    endtask

    // Monitor: every write pulse must match the oldest expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.hilo_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL unexpected_write at cycle %0d: hilo_we=1, expected 0", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("write_cycle", cyc, e.wcyc);
                    @(posedge clk);
                    #1;
                    check("lo", bus.lo, e.lo);
                    check("hi", bus.hi, e.hi);
                    check_bit("div_zero", bus.div_zero, e.dz);
                end
            end
        end
    end

    initial begin
        logic [W-1:0] a, b;
        logic         s;
        bus.mf_req    = 1'b0;
        bus.flush     = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.is_signed = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_bit("rst_busy", bus.busy, 1'b0);
        check_bit("rst_we", bus.hilo_we, 1'b0);
        check("rst_hi", bus.hi, '0);
        check("rst_lo", bus.lo, '0);
        check_bit("rst_dz", bus.div_zero, 1'b0);
        rst = 1'b1;
        step();

        run_div(32'd100, 32'd7, 1'b0);
        run_div(-32'sd7, 32'd2, 1'b1);
        run_div(32'd7, -32'sd2, 1'b1);
        run_div(32'd5, 32'd0, 1'b0);
        run_div(32'd9, 32'd3, 1'b0);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        // Flush mid-iteration: back to idle next cycle, HI/LO untouched.
        issue(32'd1234567, 32'd89, 1'b0, 1'b0);
        repeat (9) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        @(negedge clk);
        check_bit("flush_idle", bus.busy, 1'b0);
        check("flush_hi", bus.hi, last_hi);
        check("flush_lo", bus.lo, last_lo);
        check_bit("flush_dz", bus.div_zero, last_dz);
        step();

        // Flush together with start in idle: nothing accepted.
        bus.flush = 1'b1;
        issue(32'd50, 32'd5, 1'b0, 1'b0);
        bus.flush = 1'b0;
        @(negedge clk);
        check_bit("flush_start_idle", bus.busy, 1'b0);
        step();

        // Flush during the write cycle of a divide-by-zero suppresses the write.
        issue(32'd77, 32'd0, 1'b0, 1'b0);
        step();
        bus.flush = 1'b1;
        @(negedge clk);
        check_bit("flush_fix_we", bus.hilo_we, 1'b0);
        step();
        bus.flush = 1'b0;
        @(negedge clk);
        check_bit("flush_fix_idle", bus.busy, 1'b0);
        check("flush_fix_lo", bus.lo, last_lo);
        step();

        // Reset mid-operation clears HI/LO immediately.
        issue(32'd1000, 32'd3, 1'b0, 1'b0);
        repeat (19) step();
        rst = 1'b0;
        #1;
        check_bit("rst_mid_busy", bus.busy, 1'b0);
        check("rst_mid_hi", bus.hi, '0);
        check("rst_mid_lo", bus.lo, '0);
        check_bit("rst_mid_dz", bus.div_zero, 1'b0);
        last_hi = '0;
        last_lo = '0;
        last_dz = 1'b0;
        step();
        rst = 1'b1;
        step();

        // MF request and a second DIV while busy: stall until the cycle after the write.
        issue(32'd1000, 32'd10, 1'b0, 1'b1);
        for (int k = 1; k <= LAT + 1; k++) begin
            if (k == 5) bus.mf_req = 1'b1;
            if (k == 10) begin
                memctr        = MEMCTR_HILO;
                aluctr        = ALUCTR_DIV;
                bus.dividend  = 32'd600;
                bus.divisor   = 32'd25;
                bus.is_signed = 1'b0;
            end
            if (k == LAT + 1) push(32'd600, 32'd25, 1'b0);
            @(negedge clk);
            check_bit("stall", bus.stall, (k >= 5) && (k <= LAT));
            check_bit("stall_busy", bus.busy, k <= LAT);
            step();
        end
        aluctr     = 3'd0;
        bus.mf_req = 1'b0;
        finish_div(LAT);

        for (int i = 0; i < 40; i++) begin
            a = pick();
            b = pick();
            s = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) step();
            run_div(a, b, s);
        end

        check("pending_writes", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
